// File: rtl/gshare_predict.sv
// gshare direction predictor: table of saturating counters indexed by pc_IF ^ GHR,
// prediction in ID, training and GHR repair in EX, table cleared by a post-reset sweep.
module gshare_predict #(
  parameter int unsigned       INDEX_W  = 10,
  parameter int unsigned       CTR_W    = 2,
  parameter int unsigned       HIST_W   = 8,
  parameter logic [CTR_W-1:0]  INIT_CTR = CTR_W'(2**(CTR_W-1))
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] pc_IF,
  input  logic        branch_ID,
  input  logic        branch_EX,
  input  logic        branch_result_EX,
  output logic        branch_predict_ID,
  output logic        mispredict_EX,
  output logic        ready
);

  localparam int unsigned      ENTRIES = 2**INDEX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [0:0]       ST_INIT = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;

  logic [0:0]         state;
  logic [INDEX_W-1:0] init_ptr;
  logic [HIST_W-1:0]  ghr;
  logic [HIST_W-1:0]  ghr_next;
  logic [HIST_W-1:0]  hist_ID;
  logic [HIST_W-1:0]  hist_EX;
  logic [INDEX_W-1:0] idx_IF;
  logic [INDEX_W-1:0] idx_ID;
  logic [INDEX_W-1:0] idx_EX;
  logic [CTR_W-1:0]   ctr_ID;
  logic [CTR_W-1:0]   ctr_EX;
  logic [CTR_W-1:0]   ctr_train;
  logic [CTR_W-1:0]   tbl [ENTRIES];
  logic               we;
  logic [INDEX_W-1:0] waddr;
  logic [CTR_W-1:0]   wdata;
  logic               run;
  logic               unused_pc;

  assign unused_pc = ^(pc_IF >> INDEX_W);

  assign run               = (state == ST_RUN);
  assign ready             = run;
  assign idx_IF            = pc_IF[INDEX_W-1:0] ^ INDEX_W'(ghr);
  assign branch_predict_ID = run & ctr_ID[CTR_W-1];
  assign mispredict_EX     = run & branch_EX & (branch_result_EX != ctr_EX[CTR_W-1]);

  always_comb begin
    if (branch_result_EX) ctr_train = (ctr_EX == CTR_MAX) ? CTR_MAX : ctr_EX + CTR_W'(1);
    else                  ctr_train = (ctr_EX == '0)      ? '0      : ctr_EX - CTR_W'(1);
  end

  // Single write port shared by the INIT sweep and EX training.
  always_comb begin
    we    = 1'b0;
    waddr = init_ptr;
    wdata = INIT_CTR;
    if (rstn) begin
      if (!run) begin
        we = 1'b1;
      end else if (branch_EX && !stall) begin
        we    = 1'b1;
        waddr = idx_EX;
        wdata = ctr_train;
      end
    end
  end

  // Repair from the EX snapshot outranks the speculative ID shift.
  always_comb begin
    ghr_next = ghr;
    if (mispredict_EX)                 ghr_next = HIST_W'({hist_EX, branch_result_EX});
    else if (branch_ID && !flush && run) ghr_next = HIST_W'({ghr, branch_predict_ID});
  end

  always_ff @(posedge clk) begin
    if (we) tbl[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      ghr      <= '0;
      ctr_ID   <= '0;
      idx_ID   <= '0;
      hist_ID  <= '0;
      ctr_EX   <= '0;
      idx_EX   <= '0;
      hist_EX  <= '0;
    end else if (state == ST_INIT) begin
      init_ptr <= init_ptr + INDEX_W'(1);
      if (init_ptr == '1) state <= ST_RUN;
    end else if (!stall) begin
      ghr     <= ghr_next;
      ctr_ID  <= tbl[idx_IF];
      idx_ID  <= idx_IF;
      hist_ID <= ghr;
      ctr_EX  <= ctr_ID;
      idx_EX  <= idx_ID;
      hist_EX <= hist_ID;
    end
  end

endmodule

// File: tb/tb_gshare_predict.sv
// Self-checking bench for gshare_predict: per-cycle comparison against an array/integer
// model of the predictor, plus directed vectors with hand-computed expectations.
module tb_gshare_predict;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        flush;
  logic [15:0] pc_IF;
  logic        branch_ID;
  logic        branch_EX;
  logic        branch_result_EX;
  logic        branch_predict_ID;
  logic        mispredict_EX;
  logic        ready;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  gshare_predict #(.INDEX_W(10), .CTR_W(2), .HIST_W(8)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .stall             (stall),
    .flush             (flush),
    .pc_IF             (pc_IF),
    .branch_ID         (branch_ID),
    .branch_EX         (branch_EX),
    .branch_result_EX  (branch_result_EX),
    .branch_predict_ID (branch_predict_ID),
    .mispredict_EX     (mispredict_EX),
    .ready             (ready)
  );

  // Model: counters as ints 0..3, history as an int modulo 256.
  int mtbl [1024];
  int mcnt;
  bit mready;
  int mghr;
  int mid_ctr, mid_idx, mid_hist;
  int mex_ctr, mex_idx, mex_hist;

  always @(posedge clk) begin : model
    int rd, ridx, ng;
    bit mis, pred;
    if (!rstn) begin
      mcnt = 0; mready = 1'b0; mghr = 0;
      mid_ctr = 0; mid_idx = 0; mid_hist = 0;
      mex_ctr = 0; mex_idx = 0; mex_hist = 0;
    end else if (!mready) begin
      mcnt++;
      if (mcnt == 1024) begin
        for (int i = 0; i < 1024; i++) mtbl[i] = 2;
        mready = 1'b1;
      end
    end else if (!stall) begin
      pred = (mid_ctr >= 2);
      mis  = branch_EX && (branch_result_EX != (mex_ctr >= 2));
      ridx = (int'(pc_IF) % 1024) ^ mghr;
      rd   = mtbl[ridx];
      if (branch_EX)
        mtbl[mex_idx] = branch_result_EX ? ((mex_ctr == 3) ? 3 : mex_ctr + 1)
                                         : ((mex_ctr == 0) ? 0 : mex_ctr - 1);
      if (mis)                     ng = (mex_hist * 2 + int'(branch_result_EX)) % 256;
      else if (branch_ID && !flush) ng = (mghr * 2 + int'(pred)) % 256;
      else                         ng = mghr;
      mex_ctr = mid_ctr; mex_idx = mid_idx; mex_hist = mid_hist;
      mid_ctr = rd;      mid_idx = ridx;    mid_hist = mghr;
      mghr    = ng;
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ready", ready, mready);
      cmp("branch_predict_ID", branch_predict_ID, mready && (mid_ctr >= 2));
      cmp("mispredict_EX", mispredict_EX,
          mready && branch_EX && (branch_result_EX != (mex_ctr >= 2)));
    end
  end

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic apply(input logic rs, input logic [15:0] pc, input logic bid,
                       input logic bex, input logic res, input logic st, input logic fl);
    @(posedge clk);
    #1;
    rstn = rs; pc_IF = pc; branch_ID = bid; branch_EX = bex;
    branch_result_EX = res; stall = st; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle(input logic [15:0] pc);
    apply(1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Release reset and count the INIT cycles; last_pc is fetched in the first live cycle.
  task automatic sweep(input logic [15:0] last_pc, input string tag);
    int zeros;
    zeros = 0;
    for (int i = 0; i <= 1024; i++) begin
      if (i < 1024) apply(1'b1, 16'(i * 7), 1'b1, 1'b1, 1'b1, (i < 100), 1'b0);
      else          apply(1'b1, last_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i < 1024 && ready !== 1'b1) zeros++;
    end
    chk_int({tag, "_ready_low_cycles"}, zeros, 1024);
    cmp({tag, "_ready_high"}, ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; pc_IF = '0; branch_ID = 1'b0; branch_EX = 1'b0;
    branch_result_EX = 1'b0; stall = 1'b0; flush = 1'b0;

    // 1: reset state, INIT length, first lookup
    apply(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    apply(1'b0, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("t1_rst_ready", ready, 1'b0);
    cmp("t1_rst_pred", branch_predict_ID, 1'b0);
    cmp("t1_rst_mis", mispredict_EX, 1'b0);
    sweep(16'h0005, "t1");
    idle(16'h0000);
    cmp("t1_pred_pc5", branch_predict_ID, 1'b1);

    // 2: counter walks 10 -> 01 -> 00 and saturates
    idle(16'h0040); idle(16'h0000);
    cmp("t2_pred_a", branch_predict_ID, 1'b1);
    apply(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t2_mis_first", mispredict_EX, 1'b1);
    idle(16'h0040); idle(16'h0000);
    cmp("t2_pred_b", branch_predict_ID, 1'b0);
    apply(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t2_mis_second", mispredict_EX, 1'b0);
    idle(16'h0040); idle(16'h0000);
    apply(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t2_mis_third", mispredict_EX, 1'b0);
    idle(16'h0040); idle(16'h0000);
    cmp("t2_pred_sat", branch_predict_ID, 1'b0);

    // 4: EX repair outranks ID shift; flush suppresses the shift
    idle(16'h0080); idle(16'h00C0);
    apply(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cmp("t4_pred_id", branch_predict_ID, 1'b1);
    cmp("t4_mis", mispredict_EX, 1'b1);
    idle(16'h0040); idle(16'h0000);
    cmp("t4_ghr_repaired_flush", branch_predict_ID, 1'b0);
    idle(16'h0100); idle(16'h0140);
    apply(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t4_mis_noflush", mispredict_EX, 1'b1);
    idle(16'h0040); idle(16'h0000);
    cmp("t4_ghr_repair_wins", branch_predict_ID, 1'b0);
    idle(16'h0180);
    apply(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("t4_pred_flushed", branch_predict_ID, 1'b1);
    idle(16'h0040); idle(16'h0000);
    cmp("t4_flush_no_shift", branch_predict_ID, 1'b0);

    // 5a: stall holds ID prediction and GHR
    idle(16'h0000);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cmp("t5a_pred_stall", branch_predict_ID, 1'b1);
    end
    idle(16'h0040); idle(16'h0000);
    cmp("t5a_ghr_held", branch_predict_ID, 1'b0);

    // 5b: branch held in EX over 3 stalls trains once (2 -> 1, then taken 1 -> 2)
    idle(16'h00C0); idle(16'h0000);
    cmp("t5b_pred", branch_predict_ID, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 16'h0040, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      cmp("t5b_pred_stall", branch_predict_ID, 1'b1);
      cmp("t5b_mis_stall", mispredict_EX, 1'b1);
    end
    apply(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t5b_mis_release", mispredict_EX, 1'b1);
    idle(16'h00C0); idle(16'h0000);
    cmp("t5b_pred_after", branch_predict_ID, 1'b0);
    apply(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("t5b_mis_taken", mispredict_EX, 1'b1);
    idle(16'h00C1); idle(16'h0000);
    cmp("t5b_single_step", branch_predict_ID, 1'b1);

    // 6: reset at init_ptr=500 restarts the sweep
    apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) apply(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("t6_ready_midinit", ready, 1'b0);
    apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("t6_ready_in_reset", ready, 1'b0);
    sweep(16'h0002, "t6");

    // 3: GHR=0x01, pc 0x0003 reads entry 0x002
    idle(16'h0000);
    apply(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t3_mis_pretrain", mispredict_EX, 1'b1);
    idle(16'h0002); idle(16'h0000);
    apply(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("t3_mis_pretrain2", mispredict_EX, 1'b0);
    idle(16'h0100);
    apply(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("t3_pred_shift", branch_predict_ID, 1'b1);
    idle(16'h0003); idle(16'h0000);
    cmp("t3_xor_index", branch_predict_ID, 1'b0);
    idle(16'h0002); idle(16'h0000);
    cmp("t3_xor_index_b", branch_predict_ID, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
